// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch-side PC stage
//
// Purpose : FSM state encoding, next-PC select encoding, PC step and
//           default HALT encoding shared by program_counter_unit and
//           next_pc_sel.
// Ports   : none (package)
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JREG   = 2'd3
  } next_sel_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;
  localparam int          PC_STEP           = 4;

  // Redirect priority: register jump beats absolute jump beats branch.
  function automatic next_sel_e pick_sel(input logic jump_reg,
                                         input logic jump,
                                         input logic branch_taken);
    if (jump_reg)          return SEL_JREG;
    else if (jump)         return SEL_JUMP;
    else if (branch_taken) return SEL_BRANCH;
    else                   return SEL_SEQ;
  endfunction

endpackage

// File: rtl/program_counter_unit_next_pc_sel.sv
// rtl/program_counter_unit_next_pc_sel.sv - next-PC target calc, priority mux, alignment check
//
// Purpose : Purely combinational. Forms the four candidate targets from the
//           link value, picks one by priority and flags a misaligned result.
// Ports   : pc_plus4       in  current PC + 4
//           branch_taken   in  select PC-relative branch
//           branch_offset  in  sign-extended word offset
//           jump           in  select J-format absolute jump
//           jump_target    in  26-bit J-format target field
//           jump_reg       in  select register jump
//           jr_addr        in  register jump address
//           next_pc        out selected next PC
//           next_misalign  out next_pc[1:0] != 0
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              next_misalign
);

  next_sel_e         sel;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] jump_pc;

  // Word offset to byte offset; the add wraps modulo 2^ADDR_W.
  assign branch_pc = pc_plus4 + {branch_offset[ADDR_W-3:0], 2'b00};
  // Region bits come from the link value, not the current PC.
  assign jump_pc   = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};
  assign sel       = pick_sel(jump_reg, jump, branch_taken);

  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      SEL_SEQ:    next_pc = pc_plus4;
      SEL_BRANCH: next_pc = branch_pc;
      SEL_JUMP:   next_pc = jump_pc;
      SEL_JREG:   next_pc = jr_addr;
      default:    next_pc = pc_plus4;
    endcase
  end

  assign next_misalign = |next_pc[1:0];

endmodule

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - fetch-side PC stage with stall, redirect, HALT and FAULT
//
// Purpose : Holds the PC driving InstructionMemory.read_addr, advances it
//           sequentially or redirects it, stops on the HALT encoding and
//           stops on a misaligned target. Counts PC advances.
// Ports   : clock          in  rising-edge clock
//           reset          in  asynchronous active-low reset
//           stall          in  hold PC this cycle
//           branch_taken   in  PC-relative branch
//           branch_offset  in  sign-extended word offset
//           jump           in  J-format absolute jump
//           jump_target    in  J-format target field
//           jump_reg       in  register jump
//           jr_addr        in  register jump address
//           instruction    in  word fetched at read_addr
//           read_addr      out current PC
//           pc_plus4       out read_addr + 4 (link value)
//           halted         out high while in HALT
//           misaligned     out high while in FAULT
//           fetch_count    out saturating count of PC advances
module program_counter_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]      HALT_WORD = HALT_WORD_DEFAULT,
  parameter int               CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic [31:0]       instruction,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted,
  output logic              misaligned,
  output logic [CNT_W-1:0]  fetch_count
);

  pc_state_e         state;
  pc_state_e         state_nxt;
  logic [ADDR_W-1:0] next_pc;
  logic              next_misalign;
  logic              is_halt_word;
  logic              pc_load;

  assign pc_plus4     = read_addr + ADDR_W'(PC_STEP);
  assign is_halt_word = (instruction == HALT_WORD);

  next_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .jr_addr       (jr_addr),
    .next_pc       (next_pc),
    .next_misalign (next_misalign)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // Next-state logic. HALT is tested before the target, so a HALT word
  // wins over any redirect presented alongside it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (is_halt_word)       state_nxt = ST_HALT;
          else if (next_misalign) state_nxt = ST_FAULT;
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  // Outputs. The PC only moves on a RUN cycle that is neither stalled,
  // halting, nor faulting.
  always_comb begin
    pc_load    = 1'b0;
    halted     = 1'b0;
    misaligned = 1'b0;
    unique case (state)
      ST_RUN:   pc_load    = !stall && !is_halt_word && !next_misalign;
      ST_HALT:  halted     = 1'b1;
      ST_FAULT: misaligned = 1'b1;
      default:  pc_load    = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_addr   <= RESET_PC;
      fetch_count <= '0;
    end else if (pc_load) begin
      read_addr <= next_pc;
      if (fetch_count != {CNT_W{1'b1}}) fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
